// File: rtl/l3_pkg.sv
// l3_pkg: shared definitions for the L3 command master.
//   - l3_state_e   : command master FSM state encoding
//   - L3_DW        : L3 data-path width in bits
//   - TO_RESP_DEF  : response code reported to the host when a command times out
package l3_pkg;

    localparam int L3_DW = 32;

    localparam logic [7:0] TO_RESP_DEF = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WR   = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } l3_state_e;

endpackage

// File: rtl/l3_cmd_master_if.sv
// l3_cmd_master_if: core-facing L3 command bus.
//   master modport (command master): drives the command strobe/fields, the
//     write-data stream and the read/response ready signals; receives write
//     ready, read words and the core response.
//   slave modport (session-key / crypto core side): the mirror image.
interface l3_cmd_master_if;
    import l3_pkg::*;

    logic             l3_en;
    logic [7:0]       l3_op;
    logic [15:0]      l3_extend;
    logic [15:0]      l3_size;
    logic [L3_DW-1:0] l3_wd;
    logic             l3_wd_vld;
    logic             core_wd_rdy;
    logic [L3_DW-1:0] core_rd;
    logic             core_rd_vld;
    logic             l3_rd_rdy;
    logic [7:0]       core_resp;
    logic             core_resp_vld;
    logic             resp_rdy;

    modport master (
        output l3_en, l3_op, l3_extend, l3_size, l3_wd, l3_wd_vld,
        output l3_rd_rdy, resp_rdy,
        input  core_wd_rdy, core_rd, core_rd_vld, core_resp, core_resp_vld
    );

    modport slave (
        input  l3_en, l3_op, l3_extend, l3_size, l3_wd, l3_wd_vld,
        input  l3_rd_rdy, resp_rdy,
        output core_wd_rdy, core_rd, core_rd_vld, core_resp, core_resp_vld
    );

endinterface

// File: rtl/l3m_rd_fifo.sv
// l3m_rd_fifo: synchronous read-data FIFO for the L3 command master.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous flush (empties the FIFO)
//   push/wdata : write side; a push on a full FIFO is taken only when a pop
//                happens in the same cycle (count then stays unchanged)
//   pop/rdata  : read side; rdata is the FIFO head, a pop on empty is ignored
//   full/empty : occupancy flags
module l3m_rd_fifo
    import l3_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = L3_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign rdata = mem_r[rd_ptr_r];

    // When full, the slot being written is the one being popped this cycle.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/l3_cmd_master.sv
// l3_cmd_master: initiator side of the L3 command interface.
// Takes one host command at a time, issues a one-cycle l3_en strobe with the
// latched op/extend/size, streams the write words, buffers returned read
// words and hands the core response back to the host after all read data.
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous abort (back to IDLE, FIFO flushed, response dropped)
//   req_*          : host command handshake and fields
//   host_wd*       : host write-data stream
//   host_rd*       : buffered read data (FIFO head)
//   host_resp*     : response code to the host
//   busy           : a command is in progress
//   l3             : core-side L3 bus (master modport)
module l3_cmd_master
    import l3_pkg::*;
#(
    parameter int         RD_DEPTH  = 4,
    parameter int         TO_CYCLES = 1024,
    parameter logic [7:0] TO_RESP   = TO_RESP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [7:0]       req_op,
    input  logic [15:0]      req_extend,
    input  logic [15:0]      req_size,
    input  logic [L3_DW-1:0] host_wd,
    input  logic             host_wd_vld,
    output logic             host_wd_rdy,
    output logic [L3_DW-1:0] host_rd,
    output logic             host_rd_vld,
    input  logic             host_rd_rdy,
    output logic [7:0]       host_resp,
    output logic             host_resp_vld,
    input  logic             host_resp_rdy,
    output logic             busy,
    l3_cmd_master_if.master  l3
);

    localparam int            TW      = $clog2(TO_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    l3_state_e        state_r;
    l3_state_e        state_s;
    logic [7:0]       op_r;
    logic [15:0]      extend_r;
    logic [15:0]      size_r;
    logic [15:0]      wcnt_r;
    logic [TW-1:0]    tcnt_r;
    logic [7:0]       resp_r;
    logic             req_rdy_r;

    logic             req_hs_s;
    logic             wd_hs_s;
    logic             rd_hs_s;
    logic             resp_in_s;
    logic             host_resp_hs_s;
    logic             any_hs_s;
    logic             timed_s;
    logic             timeout_s;

    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [L3_DW-1:0] fifo_head_s;

    // Handshake qualifiers; each is only meaningful in its own state.
    assign req_hs_s       = (state_r == ST_IDLE) & req_rdy_r & req_vld;
    assign wd_hs_s        = (state_r == ST_WR) & host_wd_vld & l3.core_wd_rdy;
    assign rd_hs_s        = (state_r == ST_WAIT) & l3.core_rd_vld & ~fifo_full_s;
    assign resp_in_s      = (state_r == ST_WAIT) & l3.core_resp_vld;
    assign host_resp_hs_s = (state_r == ST_RESP) & fifo_empty_s & host_resp_rdy;
    assign any_hs_s       = wd_hs_s | rd_hs_s | resp_in_s;

    // A handshake in the final cycle counts as progress and beats the timeout.
    assign timed_s   = (state_r == ST_WR) | (state_r == ST_WAIT);
    assign timeout_s = timed_s & (tcnt_r == TO_LAST) & ~any_hs_s;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_hs_s) begin
                        state_s = ST_CMD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (size_r != 16'd0) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_WR: begin
                    if (timeout_s) begin
                        state_s = ST_RESP;
                    end else if (wd_hs_s && (wcnt_r == 16'd1)) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_WR;
                    end
                end
                ST_WAIT: begin
                    if (resp_in_s || timeout_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_RESP: begin
                    if (host_resp_hs_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESP;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // req_rdy is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rdy_r <= 1'b0;
        end else begin
            req_rdy_r <= (state_s == ST_IDLE);
        end
    end

    // Command fields latched on acceptance and held for the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 8'd0;
            extend_r <= 16'd0;
            size_r   <= 16'd0;
        end else if (clr) begin
            op_r     <= 8'd0;
            extend_r <= 16'd0;
            size_r   <= 16'd0;
        end else if (req_hs_s) begin
            op_r     <= req_op;
            extend_r <= req_extend;
            size_r   <= req_size;
        end else begin
            op_r     <= op_r;
            extend_r <= extend_r;
            size_r   <= size_r;
        end
    end

    // Remaining write words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= 16'd0;
        end else if (clr) begin
            wcnt_r <= 16'd0;
        end else if (req_hs_s) begin
            wcnt_r <= req_size;
        end else if (wd_hs_s) begin
            wcnt_r <= wcnt_r - 16'd1;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Inactivity counter: restarts on any state change or handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= {TW{1'b0}};
        end else if (clr || (state_s != state_r) || any_hs_s || !timed_s) begin
            tcnt_r <= {TW{1'b0}};
        end else begin
            tcnt_r <= tcnt_r + TW'(1);
        end
    end

    // Response holding register: core response or the timeout code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r <= 8'd0;
        end else if (clr) begin
            resp_r <= 8'd0;
        end else if (timeout_s) begin
            resp_r <= TO_RESP;
        end else if (resp_in_s) begin
            resp_r <= l3.core_resp;
        end else begin
            resp_r <= resp_r;
        end
    end

    assign fifo_pop_s = ~fifo_empty_s & host_rd_rdy;

    l3m_rd_fifo #(
        .DEPTH (RD_DEPTH),
        .DW    (L3_DW)
    ) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr),
        .push  (rd_hs_s),
        .wdata (l3.core_rd),
        .pop   (fifo_pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Outputs are decoded from registered state; write data passes through in WR.
    assign req_rdy       = req_rdy_r;
    assign busy          = (state_r != ST_IDLE);
    assign host_wd_rdy   = (state_r == ST_WR) & l3.core_wd_rdy;
    assign host_rd_vld   = ~fifo_empty_s;
    assign host_rd       = fifo_empty_s ? {L3_DW{1'b0}} : fifo_head_s;
    assign host_resp_vld = (state_r == ST_RESP) & fifo_empty_s;
    assign host_resp     = resp_r;

    assign l3.l3_en      = (state_r == ST_CMD);
    assign l3.l3_op      = op_r;
    assign l3.l3_extend  = extend_r;
    assign l3.l3_size    = size_r;
    assign l3.l3_wd      = (state_r == ST_WR) ? host_wd : {L3_DW{1'b0}};
    assign l3.l3_wd_vld  = (state_r == ST_WR) & host_wd_vld;
    assign l3.l3_rd_rdy  = (state_r == ST_WAIT) & ~fifo_full_s;
    assign l3.resp_rdy   = (state_r == ST_WAIT);

endmodule

// File: tb/tb_l3_cmd_master.sv
// Self-checking bench for l3_cmd_master: table of command records run through
// a host/core model, plus directed timeout, clr and reset sequences.
module tb_l3_cmd_master;
    import l3_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        req_vld;
    logic        req_rdy;
    logic [7:0]  req_op;
    logic [15:0] req_extend;
    logic [15:0] req_size;
    logic [31:0] host_wd;
    logic        host_wd_vld;
    logic        host_wd_rdy;
    logic [31:0] host_rd;
    logic        host_rd_vld;
    logic        host_rd_rdy;
    logic [7:0]  host_resp;
    logic        host_resp_vld;
    logic        host_resp_rdy;
    logic        busy;

    l3_cmd_master_if l3i();

    l3_cmd_master #(
        .RD_DEPTH  (4),
        .TO_CYCLES (16),
        .TO_RESP   (8'hE0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_op        (req_op),
        .req_extend    (req_extend),
        .req_size      (req_size),
        .host_wd       (host_wd),
        .host_wd_vld   (host_wd_vld),
        .host_wd_rdy   (host_wd_rdy),
        .host_rd       (host_rd),
        .host_rd_vld   (host_rd_vld),
        .host_rd_rdy   (host_rd_rdy),
        .host_resp     (host_resp),
        .host_resp_vld (host_resp_vld),
        .host_resp_rdy (host_resp_rdy),
        .busy          (busy),
        .l3            (l3i)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] ext;
        logic [15:0] size;
        logic [31:0] wbase;
        logic [31:0] wstep;
        int          nrd;
        logic [31:0] rbase;
        logic [7:0]  resp;
        int          rd_hold;
        bit          wd_toggle;
        bit          resp_with_last;
    } vec_t;

    vec_t tbl [5];
    int   n_vec  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_vld             = 1'b0;
        host_wd_vld         = 1'b0;
        host_rd_rdy         = 1'b0;
        host_resp_rdy       = 1'b0;
        l3i.core_wd_rdy     = 1'b0;
        l3i.core_rd_vld     = 1'b0;
        l3i.core_resp_vld   = 1'b0;
    endtask

    // One full command through a host + core model with a FIFO occupancy model.
    task automatic run_vec(input vec_t v, input int idx);
        int wi = 0;
        int ri = 0;
        int pi = 0;
        int occ = 0;
        int en_cnt = 0;
        bit resp_cap = 1'b0;
        bit done = 1'b0;
        bit push;
        bit pop;
        @(posedge clk); #1;
        req_vld = 1'b1; req_op = v.op; req_extend = v.ext; req_size = v.size;
        @(negedge clk);
        chk($sformatf("v%0d req_rdy", idx), req_rdy, 32'd1);
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d l3_en", idx), l3i.l3_en, 32'd1);
        chk($sformatf("v%0d l3_op", idx), l3i.l3_op, v.op);
        chk($sformatf("v%0d l3_extend", idx), l3i.l3_extend, v.ext);
        chk($sformatf("v%0d l3_size", idx), l3i.l3_size, v.size);
        chk($sformatf("v%0d busy", idx), busy, 32'd1);
        chk($sformatf("v%0d req_rdy busy", idx), req_rdy, 32'd0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            host_wd           = v.wbase + v.wstep * wi;
            host_wd_vld       = (wi < int'(v.size));
            l3i.core_wd_rdy   = v.wd_toggle ? ((cyc % 2) == 0) : 1'b1;
            l3i.core_rd       = v.rbase + ri;
            l3i.core_rd_vld   = (ri < v.nrd);
            l3i.core_resp     = v.resp;
            l3i.core_resp_vld = (ri >= v.nrd) || (v.resp_with_last && (ri == v.nrd - 1));
            host_rd_rdy       = (cyc >= v.rd_hold);
            host_resp_rdy     = 1'b1;
            @(negedge clk);
            if (l3i.l3_en) en_cnt++;
            if (l3i.l3_wd_vld && host_wd_rdy) begin
                chk($sformatf("v%0d wd%0d", idx, wi), l3i.l3_wd, v.wbase + v.wstep * wi);
                wi++;
            end
            if (l3i.resp_rdy) begin
                chk($sformatf("v%0d l3_rd_rdy", idx), l3i.l3_rd_rdy, 32'(occ < 4));
            end
            chk($sformatf("v%0d host_rd_vld", idx), host_rd_vld, 32'(occ > 0));
            push = l3i.l3_rd_rdy && l3i.core_rd_vld;
            pop  = host_rd_vld && host_rd_rdy;
            if (pop) begin
                chk($sformatf("v%0d rd%0d", idx, pi), host_rd, v.rbase + pi);
                pi++;
            end
            chk($sformatf("v%0d host_resp_vld", idx), host_resp_vld, 32'(resp_cap && (occ == 0)));
            if (host_resp_vld) begin
                chk($sformatf("v%0d host_resp", idx), host_resp, v.resp);
                done = 1'b1;
            end
            if (l3i.resp_rdy && l3i.core_resp_vld) resp_cap = 1'b1;
            if (push) ri++;
            occ = occ + int'(push) - int'(pop);
        end
        chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d extra l3_en", idx), en_cnt, 32'd0);
        chk($sformatf("v%0d wd beats", idx), wi, v.size);
        chk($sformatf("v%0d rd pops", idx), pi, v.nrd);
        chk($sformatf("v%0d wcnt", idx), dut.wcnt_r, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d idle busy", idx), busy, 32'd0);
        chk($sformatf("v%0d idle req_rdy", idx), req_rdy, 32'd1);
    endtask

    initial begin
        tbl[0] = '{8'h21, 16'h0003, 16'd4, 32'h11, 32'h11, 32'd0, 32'h0, 8'h00, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{8'h30, 16'h0000, 16'd0, 32'h0, 32'h0, 32'd6, 32'hA0, 8'h5A, 32'd10, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 16'h0100, 16'd3, 32'h1000_0000, 32'h1, 32'd0, 32'h0, 8'h01, 32'd0, 1'b1, 1'b0};
        tbl[3] = '{8'h44, 16'h0002, 16'd1, 32'hCAFE_0000, 32'h0, 32'd1, 32'hB000_0001, 8'h33, 32'd0, 1'b0, 1'b1};
        tbl[4] = '{8'h35, 16'hFFFF, 16'd2, 32'h2, 32'h2, 32'd3, 32'h3000_0000, 8'h7F, 32'd3, 1'b1, 1'b0};

        rst_n = 1'b0; clr = 1'b0;
        req_op = 8'h00; req_extend = 16'h0000; req_size = 16'h0000;
        host_wd = 32'h0; l3i.core_rd = 32'h0; l3i.core_resp = 8'h00;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_rdy", req_rdy, 32'd0);
        chk("rst busy", busy, 32'd0);
        chk("rst l3_en", l3i.l3_en, 32'd0);
        chk("rst l3_op", l3i.l3_op, 32'd0);
        chk("rst l3_size", l3i.l3_size, 32'd0);
        chk("rst host_rd_vld", host_rd_vld, 32'd0);
        chk("rst host_resp_vld", host_resp_vld, 32'd0);
        chk("rst resp_rdy", l3i.resp_rdy, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post-rst req_rdy", req_rdy, 32'd1);

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

        // Timeout: write of 2 words with the core never ready; a second
        // request held high while busy must be ignored.
        @(posedge clk); #1;
        req_vld = 1'b1; req_op = 8'h60; req_extend = 16'h0000; req_size = 16'd2;
        host_wd = 32'hDEAD_0001; host_wd_vld = 1'b1;
        @(posedge clk); #1;
        req_op = 8'h77;
        @(negedge clk);
        chk("to l3_en", l3i.l3_en, 32'd1);
        chk("to l3_op", l3i.l3_op, 32'h60);
        for (int n = 0; n <= 16; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (n < 16) begin
                chk($sformatf("to resp_vld c%0d", n), host_resp_vld, 32'd0);
                chk($sformatf("to wd_rdy c%0d", n), host_wd_rdy, 32'd0);
                chk($sformatf("to l3_en c%0d", n), l3i.l3_en, 32'd0);
            end else begin
                chk("to resp_vld", host_resp_vld, 32'd1);
                chk("to resp", host_resp, 32'hE0);
                chk("to busy", busy, 32'd1);
                chk("to op kept", l3i.l3_op, 32'h60);
            end
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(negedge clk);
        chk("to resp held", host_resp_vld, 32'd1);
        @(posedge clk); #1;
        host_resp_rdy = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("to busy after hs", busy, 32'd0);
        chk("to req_rdy after hs", req_rdy, 32'd1);

        // clr while waiting with two words buffered.
        @(posedge clk); #1;
        req_vld = 1'b1; req_op = 8'h50; req_size = 16'd0;
        @(posedge clk); #1;
        req_vld = 1'b0; l3i.core_rd = 32'hC0; l3i.core_rd_vld = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        l3i.core_rd = 32'hC1;
        @(posedge clk); #1;
        l3i.core_rd_vld = 1'b0;
        @(negedge clk);
        chk("clr pre rd_vld", host_rd_vld, 32'd1);
        chk("clr pre rd", host_rd, 32'hC0);
        chk("clr pre resp_rdy", l3i.resp_rdy, 32'd1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr req_rdy", req_rdy, 32'd1);
        chk("clr host_rd_vld", host_rd_vld, 32'd0);
        chk("clr host_resp_vld", host_resp_vld, 32'd0);
        chk("clr busy", busy, 32'd0);
        chk("clr l3_en", l3i.l3_en, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr l3_en later", l3i.l3_en, 32'd0);

        run_vec(tbl[0], 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
